univ_shift_reg_p: RTL and testbench
===================================

# univ_shift_reg_p

Parametrised universal shift register: WIDTH-bit register with hold, logical/arithmetic shift, rotate, parallel and bit-reversed load, plus an autonomous burst-shift engine that shifts N positions under a start/busy/done handshake. It is the generalised successor of the team's 4-bit universal register. It serves as the serialiser/deserialiser and bit-alignment element in datapath and serial-link blocks.

## Interface
- WIDTH, 8, register width (≥ 2)
- LEN_W, $clog2(WIDTH)+1, burst length width (derived, do not override)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  clock enable; all state and the register hold when 0
- mode  input  3  operation select (see Operation)
- p_din  input  WIDTH  parallel data in
- s_left_din  input  1  serial in at MSB side (enters on right shifts)
- s_right_din  input  1  serial in at LSB side (enters on left shifts)
- start  input  1  burst request, sampled in IDLE
- burst_len  input  LEN_W  burst shift count, captured with start
- burst_dir  input  1  0 = right, 1 = left
- p_dout  output  WIDTH  register contents q
- s_left_dout  output  1  q[WIDTH-1]
- s_right_dout  output  1  q[0]
- busy  output  1  high while in BUSY
- done  output  1  one-cycle pulse on burst completion
- parity  output  1  present only with USR_PARITY_EN

## Operation
- Modes, applied when en=1 and the FSM is not in BUSY, and not in the start-capture cycle:
  - 0 hold
  - 1 SHR: q <= {s_left_din, q[W-1:1]}
  - 2 SHL: q <= {q[W-2:0], s_right_din}
  - 3 LOAD: q <= p_din
  - 4 ROR: q <= {q[0], q[W-1:1]}
  - 5 ROL: q <= {q[W-2:0], q[W-1]}
  - 6 ASR: q <= {q[W-1], q[W-1:1]}
  - 7 RLOAD: q <= bit-reverse(p_din)
- FSM states: IDLE, BUSY, DONE.
  - IDLE, en=1, start=1: capture burst_len and burst_dir into cnt/dir; mode is ignored that cycle. Next state is BUSY if burst_len≠0, otherwise DONE.
  - BUSY, en=1: one shift per cycle in dir (SHR or SHL semantics with live serial inputs); cnt decrements. The transition to DONE happens on the edge that performs the shift with cnt=1. mode and start are ignored.
  - DONE: done=1 for this cycle; mode is honoured, start is ignored; next state IDLE. Entry to and exit from DONE do not depend on en.
- burst_len > WIDTH is legal; excess shifts fill the register with serial input.
- en=0 in BUSY pauses the burst; cnt and q hold; busy stays 1.
- start asserted outside IDLE is ignored and not queued.

## Timing
- Reset (asynchronous, immediate): q=0, so p_dout=0, s_left_dout=0 and s_right_dout=0. State=IDLE, busy=0, done=0, cnt=0. A reset mid-burst aborts the burst with no done pulse.
- Mode operations have 1-cycle latency: the result is visible on p_dout after the next rising edge.
- Serial outputs and parity are combinational from q; there is no extra latency.
- Burst with start accepted at edge k, len=N>0, en held high:
  - busy=1 after edge k through edge k+N.
  - Shifts occur at edges k+1 … k+N.
  - done=1 after edge k+N for one cycle; IDLE after edge k+N+1.
- Burst with len=0: done=1 after edge k; busy is never asserted; q is unchanged.

## Configuration
- USR_PARITY_EN defined: adds output parity = ^q (even-parity bit of the register contents), combinational, 0 out of reset.
- USR_PARITY_EN undefined: no parity port and no parity logic; all other behaviour is identical.

## Test plan
- Reset: drive rst_n=0 mid-burst (with q≠0) -> p_dout=8'h00, busy=0, done=0 immediately, without waiting for a clock edge; no done pulse afterwards.
- Mode sweep, WIDTH=8:
  - LOAD 8'hB4 -> 8'hB4
  - ROR -> 8'h5A
  - ROL -> 8'hB4
  - ASR -> 8'hDA
  - RLOAD p_din=8'h01 -> 8'h80
  - mode 0 -> holds 8'h80
- Serial: start from 8'h00, SHR with s_left_din=1 for 4 cycles -> 8'hF0. Then SHL with s_right_din=0 for 4 cycles -> 8'h00, with s_left_dout=1 on each of those 4 cycles.
- Burst: q=8'h81, start with len=3, dir=left, s_right_din=0 -> busy high for 3 cycles; p_dout steps 8'h02, 8'h04, 8'h08; done pulses for exactly one cycle after the third shift; a start asserted during busy is ignored.
- Boundary:
  - len=0 -> done pulses the next cycle, busy stays 0, q unchanged.
  - en=0 for 2 cycles mid-burst -> busy stays high, q frozen, completion delayed by 2 cycles.
  - len=15 with WIDTH=8 and s_left_din=1, dir=right -> 8'hFF.
- Parity, compiled with USR_PARITY_EN: LOAD 8'h07 -> parity=1; LOAD 8'h03 -> parity=0. Compiled without the macro, the bench still builds and passes every other scenario.

Source files
------------

// File: rtl/univ_shift_reg_p_if.sv
// Port bundle for univ_shift_reg_p: control, data and burst handshake signals.
// The parity signal exists only when USR_PARITY_EN is defined.
interface univ_shift_reg_p_if #(
  parameter int WIDTH = 8
);
  localparam int LEN_W = $clog2(WIDTH) + 1;

  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] p_din;
  logic             s_left_din;
  logic             s_right_din;
  logic             start;
  logic [LEN_W-1:0] burst_len;
  logic             burst_dir;
  logic [WIDTH-1:0] p_dout;
  logic             s_left_dout;
  logic             s_right_dout;
  logic             busy;
  logic             done;
`ifdef USR_PARITY_EN
  logic             parity;
`endif

  modport master (
    output en, mode, p_din, s_left_din, s_right_din, start, burst_len, burst_dir,
`ifdef USR_PARITY_EN
    input  parity,
`endif
    input  p_dout, s_left_dout, s_right_dout, busy, done
  );

  modport slave (
    input  en, mode, p_din, s_left_din, s_right_din, start, burst_len, burst_dir,
`ifdef USR_PARITY_EN
    output parity,
`endif
    output p_dout, s_left_dout, s_right_dout, busy, done
  );
endinterface

// File: rtl/univ_shift_reg_p.sv
// Parametrised universal shift register with an N-position burst-shift engine.
// Define USR_PARITY_EN to add the combinational even-parity output.
//
// state | meaning
// IDLE  | mode operations applied; start captures burst_len/burst_dir
// BUSY  | one shift per enabled cycle in dir; cnt counts down to 1
// DONE  | done pulse; mode honoured, start ignored; returns to IDLE
module univ_shift_reg_p #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  univ_shift_reg_p_if.slave bus
);
  localparam int LEN_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [LEN_W-1:0] cnt;
  logic             dir;
  logic             busy_r;
  logic             done_r;

  logic [WIDTH-1:0] shr_q;
  logic [WIDTH-1:0] shl_q;
  logic [WIDTH-1:0] rev_din;
  logic [WIDTH-1:0] mode_q;

  assign shr_q = {bus.s_left_din, q[WIDTH-1:1]};
  assign shl_q = {q[WIDTH-2:0], bus.s_right_din};

  always_comb begin
    rev_din = '0;
    for (int i = 0; i < WIDTH; i++) rev_din[i] = bus.p_din[WIDTH-1-i];
    mode_q = q;
    case (bus.mode)
      3'd0: mode_q = q;
      3'd1: mode_q = shr_q;
      3'd2: mode_q = shl_q;
      3'd3: mode_q = bus.p_din;
      3'd4: mode_q = {q[0], q[WIDTH-1:1]};
      3'd5: mode_q = {q[WIDTH-2:0], q[WIDTH-1]};
      3'd6: mode_q = {q[WIDTH-1], q[WIDTH-1:1]};
      3'd7: mode_q = rev_din;
      default: mode_q = q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      q      <= '0;
      cnt    <= '0;
      dir    <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            if (bus.start) begin
              cnt <= bus.burst_len;
              dir <= bus.burst_dir;
              if (bus.burst_len != '0) begin
                state  <= BUSY;
                busy_r <= 1'b1;
              end else begin
                state  <= DONE;
                done_r <= 1'b1;
              end
            end else begin
              q <= mode_q;
            end
          end
        end
        BUSY: begin
          // en=0 pauses the burst with q and cnt frozen
          if (bus.en) begin
            q   <= dir ? shl_q : shr_q;
            cnt <= cnt - 1'b1;
            if (cnt == LEN_W'(1)) begin
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
          if (bus.en) q <= mode_q;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.p_dout       = q;
  assign bus.s_left_dout  = q[WIDTH-1];
  assign bus.s_right_dout = q[0];
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
`ifdef USR_PARITY_EN
  assign bus.parity       = ^q;
`endif
endmodule

// File: tb/tb_univ_shift_reg_p.sv
// Scoreboard bench for univ_shift_reg_p (WIDTH=8): expectations queued per driven
// cycle, popped and compared one cycle later. Parity checks need USR_PARITY_EN.
module tb_univ_shift_reg_p;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  univ_shift_reg_p_if #(.WIDTH(WIDTH)) bus ();

  univ_shift_reg_p #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // queue the expected post-edge state, advance one clock, pop and compare
  task automatic cyc(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    exp_t e;
    e.tag = tag; e.q = eq; e.busy = eb; e.done = ed;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".q"},    32'(bus.p_dout), 32'(e.q));
    chk({e.tag, ".busy"}, 32'(bus.busy),   32'(e.busy));
    chk({e.tag, ".done"}, 32'(bus.done),   32'(e.done));
  endtask

  task automatic set_mode(input logic [2:0] m, input logic [7:0] d);
    bus.mode = m; bus.p_din = d;
  endtask

  initial begin
    logic [7:0] exp_q;
    bus.en = 1'b0; bus.mode = 3'd0; bus.p_din = '0;
    bus.s_left_din = 1'b0; bus.s_right_din = 1'b0;
    bus.start = 1'b0; bus.burst_len = '0; bus.burst_dir = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.q",    32'(bus.p_dout),       32'h00);
    chk("rst.busy", 32'(bus.busy),         32'h0);
    chk("rst.done", 32'(bus.done),         32'h0);
    chk("rst.sl",   32'(bus.s_left_dout),  32'h0);
    chk("rst.sr",   32'(bus.s_right_dout), 32'h0);
    rst_n = 1'b1;
    bus.en = 1'b1;

    // mode sweep
    set_mode(3'd3, 8'hB4); cyc("load", 8'hB4, 0, 0);
    set_mode(3'd4, 8'h00); cyc("ror",  8'h5A, 0, 0);
    set_mode(3'd5, 8'h00); cyc("rol",  8'hB4, 0, 0);
    set_mode(3'd6, 8'h00); cyc("asr",  8'hDA, 0, 0);
    set_mode(3'd7, 8'h01); cyc("rload", 8'h80, 0, 0);
    set_mode(3'd0, 8'hFF); cyc("hold", 8'h80, 0, 0);

    // serial in/out
    set_mode(3'd3, 8'h00); cyc("clr", 8'h00, 0, 0);
    bus.s_left_din = 1'b1; set_mode(3'd1, 8'h00);
    cyc("shr1", 8'h80, 0, 0);
    cyc("shr2", 8'hC0, 0, 0);
    cyc("shr3", 8'hE0, 0, 0);
    cyc("shr4", 8'hF0, 0, 0);
    bus.s_right_din = 1'b0; set_mode(3'd2, 8'h00);
    chk("shl1.sl", 32'(bus.s_left_dout), 32'h1); cyc("shl1", 8'hE0, 0, 0);
    chk("shl2.sl", 32'(bus.s_left_dout), 32'h1); cyc("shl2", 8'hC0, 0, 0);
    chk("shl3.sl", 32'(bus.s_left_dout), 32'h1); cyc("shl3", 8'h80, 0, 0);
    chk("shl4.sl", 32'(bus.s_left_dout), 32'h1); cyc("shl4", 8'h00, 0, 0);
    bus.s_left_din = 1'b0;

    // burst left by 3, start held high during busy, mode ignored
    set_mode(3'd3, 8'h81); cyc("bload", 8'h81, 0, 0);
    chk("bload.sr", 32'(bus.s_right_dout), 32'h1);
    bus.start = 1'b1; bus.burst_len = 4'd3; bus.burst_dir = 1'b1;
    set_mode(3'd3, 8'hFF);
    cyc("bstart", 8'h81, 1, 0);
    bus.burst_len = 4'd7;
    cyc("bsh1", 8'h02, 1, 0);
    cyc("bsh2", 8'h04, 1, 0);
    cyc("bsh3", 8'h08, 0, 1);
    bus.start = 1'b0; set_mode(3'd0, 8'h00);
    cyc("bidle", 8'h08, 0, 0);
    cyc("bnoq",  8'h08, 0, 0);

    // zero-length burst
    bus.start = 1'b1; bus.burst_len = 4'd0;
    cyc("len0", 8'h08, 0, 1);
    bus.start = 1'b0;
    cyc("len0.after", 8'h08, 0, 0);

    // en=0 pause mid-burst, right shifts
    set_mode(3'd3, 8'h81); cyc("pload", 8'h81, 0, 0);
    set_mode(3'd0, 8'h00);
    bus.start = 1'b1; bus.burst_len = 4'd3; bus.burst_dir = 1'b0; bus.s_left_din = 1'b0;
    cyc("pstart", 8'h81, 1, 0);
    bus.start = 1'b0;
    cyc("psh1", 8'h40, 1, 0);
    bus.en = 1'b0;
    cyc("pause1", 8'h40, 1, 0);
    cyc("pause2", 8'h40, 1, 0);
    bus.en = 1'b1;
    cyc("psh2", 8'h20, 1, 0);
    cyc("psh3", 8'h10, 0, 1);
    cyc("pidle", 8'h10, 0, 0);

    // burst longer than WIDTH fills with serial input
    bus.start = 1'b1; bus.burst_len = 4'd15; bus.burst_dir = 1'b0; bus.s_left_din = 1'b1;
    cyc("lstart", 8'h10, 1, 0);
    bus.start = 1'b0;
    exp_q = 8'h10;
    for (int i = 1; i <= 15; i++) begin
      exp_q = {1'b1, exp_q[7:1]};
      cyc($sformatf("lsh%0d", i), exp_q, (i != 15), (i == 15));
    end
    chk("long.final", 32'(bus.p_dout), 32'hFF);
    bus.s_left_din = 1'b0;
    cyc("lidle", 8'hFF, 0, 0);

`ifdef USR_PARITY_EN
    set_mode(3'd3, 8'h07); cyc("par07", 8'h07, 0, 0);
    chk("par07.p", 32'(bus.parity), 32'h1);
    set_mode(3'd3, 8'h03); cyc("par03", 8'h03, 0, 0);
    chk("par03.p", 32'(bus.parity), 32'h0);
`endif

    // async reset mid-burst
    set_mode(3'd3, 8'h81); cyc("rload81", 8'h81, 0, 0);
    set_mode(3'd0, 8'h00);
    bus.start = 1'b1; bus.burst_len = 4'd5; bus.burst_dir = 1'b1; bus.s_right_din = 1'b0;
    cyc("rbstart", 8'h81, 1, 0);
    bus.start = 1'b0;
    cyc("rbsh1", 8'h02, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.q",    32'(bus.p_dout), 32'h00);
    chk("arst.busy", 32'(bus.busy),   32'h0);
    chk("arst.done", 32'(bus.done),   32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) cyc($sformatf("post_rst%0d", i), 8'h00, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
